h2f_desc_fetch: RTL and testbench

Fabric-side consumer of the HPS-to-FPGA register bank. Polls a doorbell register through the bank's fabric read port (register select out, register data in). When software posts a new sequence number, it copies a fixed-length descriptor out of consecutive registers and re-checks the doorbell to reject torn updates. It then presents the descriptor to downstream fabric logic on a valid/ready handshake.

---
 rtl/h2f_pkg.sv | 19 +
 rtl/h2f_desc_fetch.sv | 141 ++++++++++++++
 tb/tb_h2f_desc_fetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/h2f_pkg.sv
// Shared definitions for the HPS-to-FPGA descriptor fetch path.
//   state_t    : fetch FSM states
//   DB_EN_BIT  : doorbell enable bit
//   DB_SEQ_LSB : doorbell sequence field LSB
//   SEQ_W      : sequence number width
package h2f_pkg;

  typedef enum logic [1:0] {
    POLL    = 2'd0,
    FETCH   = 2'd1,
    VERIFY  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam int DB_EN_BIT  = 63;
  localparam int DB_SEQ_LSB = 0;
  localparam int SEQ_W      = 16;

endpackage

// File: rtl/h2f_desc_fetch.sv
// Fabric-side consumer of the HPS-to-FPGA register bank.
// Polls the doorbell through the bank read port. On a new sequence number it
// copies DESC_WORDS consecutive registers, re-reads the doorbell to reject torn
// updates, then offers the descriptor on a valid/ready handshake.
// Ports:
//   i_clk, i_arstn     : clock, async active-low reset
//   o_regsel/i_regdata : bank read port (combinational data for the select)
//   o_desc_*           : descriptor stream (valid/ready, data, seq)
//   o_busy             : FSM not in POLL
//   o_seq_gap, o_torn  : one-cycle event pulses from VERIFY
//   o_accept_count     : descriptors handed off, wraps
module h2f_desc_fetch
  import h2f_pkg::*;
#(
  parameter int DATAWIDTH    = 64,
  parameter int TOTREG       = 32,
  parameter int DOORBELL_IDX = 0,
  parameter int DESC_BASE    = 1,
  parameter int DESC_WORDS   = 4
) (
  input  logic                            i_clk,
  input  logic                            i_arstn,
  output logic [$clog2(TOTREG)-1:0]       o_regsel,
  input  logic [DATAWIDTH-1:0]            i_regdata,
  output logic                            o_desc_valid,
  input  logic                            i_desc_ready,
  output logic [DESC_WORDS*DATAWIDTH-1:0] o_desc_data,
  output logic [SEQ_W-1:0]                o_desc_seq,
  output logic                            o_busy,
  output logic                            o_seq_gap,
  output logic                            o_torn,
  output logic [31:0]                     o_accept_count
);

  localparam int RSW = $clog2(TOTREG);
  localparam int K_W = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
  localparam logic [RSW-1:0] DB_SEL   = RSW'(DOORBELL_IDX);
  localparam logic [RSW-1:0] BASE_SEL = RSW'(DESC_BASE);
  localparam logic [K_W-1:0] K_LAST   = K_W'(DESC_WORDS - 1);

  if ((DESC_BASE + DESC_WORDS > TOTREG) ||
      ((DOORBELL_IDX >= DESC_BASE) && (DOORBELL_IDX < DESC_BASE + DESC_WORDS)))
  begin : g_bad_map
    $error("h2f_desc_fetch: descriptor range overflows bank or covers the doorbell");
  end

  state_t               state, state_nxt;
  logic [K_W-1:0]       k;
  logic [SEQ_W-1:0]     last_seq, cap_seq;
  logic [DATAWIDTH-1:0] desc_buf [DESC_WORDS];

  logic             db_en;
  logic [SEQ_W-1:0] db_seq;
  logic             new_post, verify_ok, accept;
  logic             unused_regdata;

  assign db_en     = i_regdata[DB_EN_BIT];
  assign db_seq    = i_regdata[DB_SEQ_LSB +: SEQ_W];
  // Only enable and seq are meaningful; fold the rest so nothing dangles.
  assign unused_regdata = ^i_regdata;

  assign new_post  = db_en && (db_seq != last_seq);
  assign verify_ok = db_en && (db_seq == cap_seq);
  assign accept    = o_desc_valid && i_desc_ready;
  assign o_busy    = (state != POLL);

  for (genvar w = 0; w < DESC_WORDS; w++) begin : g_flat
    assign o_desc_data[w*DATAWIDTH +: DATAWIDTH] = desc_buf[w];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      POLL:    if (new_post)   state_nxt = FETCH;
      FETCH:   if (k == K_LAST) state_nxt = VERIFY;
      VERIFY:  state_nxt = verify_ok ? PRESENT : POLL;
      PRESENT: if (accept)     state_nxt = POLL;
      default: state_nxt = POLL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) state <= POLL;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      o_regsel       <= DB_SEL;
      k              <= '0;
      last_seq       <= '0;
      cap_seq        <= '0;
      o_desc_valid   <= 1'b0;
      o_desc_seq     <= '0;
      o_seq_gap      <= 1'b0;
      o_torn         <= 1'b0;
      o_accept_count <= '0;
      for (int i = 0; i < DESC_WORDS; i++) desc_buf[i] <= '0;
    end else begin
      o_seq_gap <= 1'b0;
      o_torn    <= 1'b0;
      case (state)
        POLL: begin
          if (new_post) begin
            cap_seq  <= db_seq;
            k        <= '0;
            o_regsel <= BASE_SEL;
          end
        end
        FETCH: begin
          desc_buf[k] <= i_regdata;
          if (k == K_LAST) begin
            o_regsel <= DB_SEL;
          end else begin
            k        <= k + K_W'(1);
            o_regsel <= o_regsel + RSW'(1);
          end
        end
        VERIFY: begin
          // o_regsel is back on the doorbell, so i_regdata is a fresh read.
          if (verify_ok) begin
            last_seq     <= cap_seq;
            o_desc_seq   <= cap_seq;
            o_desc_valid <= 1'b1;
            o_seq_gap    <= (cap_seq != SEQ_W'(last_seq + SEQ_W'(1)));
          end else begin
            o_torn <= 1'b1;
          end
        end
        PRESENT: begin
          if (accept) begin
            o_desc_valid   <= 1'b0;
            o_accept_count <= o_accept_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_h2f_desc_fetch.sv
module tb_h2f_desc_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   o_regsel;
  logic [63:0]  i_regdata;
  logic         o_desc_valid;
  logic         i_desc_ready = 1'b0;
  logic [255:0] o_desc_data;
  logic [15:0]  o_desc_seq;
  logic         o_busy, o_seq_gap, o_torn;
  logic [31:0]  o_accept_count;

  logic [63:0]  bank [32];

  always #5 clk = ~clk;
  always_comb i_regdata = bank[o_regsel];

  h2f_desc_fetch dut (
    .i_clk(clk), .i_arstn(rst_n),
    .o_regsel(o_regsel), .i_regdata(i_regdata),
    .o_desc_valid(o_desc_valid), .i_desc_ready(i_desc_ready),
    .o_desc_data(o_desc_data), .o_desc_seq(o_desc_seq),
    .o_busy(o_busy), .o_seq_gap(o_seq_gap), .o_torn(o_torn),
    .o_accept_count(o_accept_count)
  );

  typedef struct {
    logic [255:0] data;
    logic [15:0]  seq;
    logic         gap;
  } exp_t;

  exp_t q[$];
  int   nchk = 0, nerr = 0, torn_cnt = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] w4(input logic [63:0] b);
    return {b + 64'd3, b + 64'd2, b + 64'd1, b};
  endfunction

  task automatic set_words(input logic [63:0] b);
    for (int i = 0; i < 4; i++) bank[1+i] = b + 64'(i);
  endtask

  task automatic ring(input logic en, input logic [15:0] s);
    bank[0] = {en, 47'd0, s};
  endtask

  task automatic push(input logic [63:0] b, input logic [15:0] s, input logic g);
    exp_t e;
    e.data = w4(b); e.seq = s; e.gap = g;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic want, input string name);
    int n = 0;
    while (o_busy !== want && n < 100) begin tick(1); n++; end
    if (o_busy !== want) begin
      nchk++; nerr++;
      $display("FAIL %s: timeout, busy=%0b want %0b", name, o_busy, want);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (o_desc_valid !== 1'b1 && n < 100) begin tick(1); n++; end
    if (o_desc_valid !== 1'b1) begin
      nchk++; nerr++;
      $display("FAIL %s: timeout, valid=%0b want 1", name, o_desc_valid);
    end
  endtask

  task automatic wait_count(input logic [31:0] target, input string name);
    int n = 0;
    while (o_accept_count !== target && n < 100) begin tick(1); n++; end
    if (o_accept_count !== target) begin
      nchk++; nerr++;
      $display("FAIL %s: timeout, count=%0d want %0d", name, o_accept_count, target);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold stability.
  logic         prev_v = 1'b0;
  logic         gap_rise = 1'b0;
  logic [255:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (o_torn) torn_cnt++;
      if (o_desc_valid && !prev_v) begin
        gap_rise = o_seq_gap;
        held     = o_desc_data;
      end else if (o_desc_valid) begin
        chk("hold_data", o_desc_data, held);
      end
      if (o_desc_valid && i_desc_ready) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_desc: got seq %0d want none", o_desc_seq);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("desc_data", o_desc_data, e.data);
          chk("desc_seq", o_desc_seq, e.seq);
          chk("seq_gap", gap_rise, e.gap);
        end
      end
      prev_v = o_desc_valid;
    end
  end

  initial begin
    logic quiet;
    for (int i = 0; i < 32; i++) bank[i] = '0;
    tick(3);
    chk("rst_regsel", o_regsel, 0);
    chk("rst_valid", o_desc_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_count", o_accept_count, 0);
    chk("rst_data", o_desc_data, 0);
    chk("rst_seq", o_desc_seq, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(2);

    // First post, latency to valid
    set_words(64'hA0);
    push(64'hA0, 16'd1, 1'b0);
    ring(1'b1, 16'd1);
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      if (c == 1) begin
        chk("lat_busy_c1", o_busy, 1);
        chk("lat_regsel_c1", o_regsel, 1);
      end
      if (c == 5) chk("lat_valid_c5", o_desc_valid, 0);
      if (c == 6) begin
        chk("lat_valid_c6", o_desc_valid, 1);
        chk("lat_seq_c6", o_desc_seq, 1);
        chk("lat_gap_c6", o_seq_gap, 0);
      end
    end
    chk("count_before_ready", o_accept_count, 0);
    i_desc_ready = 1'b1;
    tick(1);
    chk("count_after_ready", o_accept_count, 1);
    chk("valid_after_ready", o_desc_valid, 0);

    // Skipped sequence number
    set_words(64'hC0);
    push(64'hC0, 16'd3, 1'b1);
    ring(1'b1, 16'd3);
    wait_busy(1'b1, "gap_start");
    wait_busy(1'b0, "gap_done");
    chk("gap_count", o_accept_count, 2);

    // Torn: seq 4 overwritten by seq 5 mid-fetch; only seq 5 is handed off,
    // and 5 is not 3+1 so the gap flag is expected.
    set_words(64'hD0);
    ring(1'b1, 16'd4);
    tick(2);
    set_words(64'hE0);
    ring(1'b1, 16'd5);
    push(64'hE0, 16'd5, 1'b1);
    wait_count(32'd3, "torn_retry");
    chk("torn_pulses", torn_cnt, 1);
    tick(2);

    // Backpressure: ready low for 10 cycles, bank rewritten during the hold
    i_desc_ready = 1'b0;
    set_words(64'hF0);
    push(64'hF0, 16'd6, 1'b0);
    ring(1'b1, 16'd6);
    wait_valid("bp_valid");
    tick(3);
    set_words(64'h70);
    ring(1'b1, 16'd7);
    push(64'h70, 16'd7, 1'b0);
    tick(7);
    chk("bp_valid_held", o_desc_valid, 1);
    chk("bp_count_held", o_accept_count, 3);
    chk("bp_seq_held", o_desc_seq, 6);
    chk("bp_data_held", o_desc_data, w4(64'hF0));
    i_desc_ready = 1'b1;
    tick(1);
    i_desc_ready = 1'b0;
    chk("bp_count_accept", o_accept_count, 4);
    chk("bp_valid_drop", o_desc_valid, 0);
    wait_valid("bp_next_valid");
    i_desc_ready = 1'b1;
    wait_count(32'd5, "bp_next_accept");

    // Disabled doorbell, then seq 0, straight out of reset
    rst_n = 1'b0;
    ring(1'b0, 16'd5);
    tick(2);
    chk("rst2_regsel", o_regsel, 0);
    chk("rst2_valid", o_desc_valid, 0);
    chk("rst2_count", o_accept_count, 0);
    chk("rst2_seq", o_desc_seq, 0);
    chk("rst2_data", o_desc_data, 0);
    chk("rst2_pulses", {o_seq_gap, o_torn}, 0);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(1); if (o_busy !== 1'b0) quiet = 1'b0; end
    chk("en0_no_fetch", quiet, 1);
    ring(1'b1, 16'd0);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(1); if (o_busy !== 1'b0) quiet = 1'b0; end
    chk("seq0_no_fetch", quiet, 1);

    // Reset while presenting; seq 1 is then accepted again without a gap
    i_desc_ready = 1'b0;
    set_words(64'h90);
    ring(1'b1, 16'd1);
    wait_valid("pres_valid");
    chk("pres_seq", o_desc_seq, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", o_desc_valid, 0);
    chk("async_busy", o_busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    push(64'h90, 16'd1, 1'b0);
    i_desc_ready = 1'b1;
    wait_count(32'd1, "repost");
    tick(2);

    chk("queue_empty", q.size(), 0);
    chk("torn_total", torn_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
